// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: opcodes, ALU selects and sequencer state encoding
package cpu_seq_pkg;
   localparam logic [3:0] OP_LDI  = 4'h0;
   localparam logic [3:0] OP_MOV  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_LD   = 4'h6;
   localparam logic [3:0] OP_ST   = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_BZ   = 4'h9;
   localparam logic [3:0] OP_HALT = 4'hF;
   localparam logic [2:0] ALU_FWD = 3'b000;
   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   typedef enum logic [2:0] {S_FETCH, S_FETCH2, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
endpackage

// File: rtl/cpu_seq_decode.sv
// cpu_seq_decode: combinational opcode decode into ALU controls and instruction class
module cpu_seq_decode
   import cpu_seq_pkg::*;
(
   input  logic [3:0] op_i,
   output logic [2:0] alu_op_o,
   output logic       is_add_o,
   output logic       is_imm_o,
   output logic       two_byte_o,
   output logic       is_mem_o,
   output logic       is_jump_o
);
   assign alu_op_o   = (op_i == OP_ADD || op_i == OP_SUB) ? ALU_ADD :
                       op_i == OP_AND ? ALU_AND :
                       op_i == OP_OR  ? ALU_OR  : ALU_FWD;
   assign is_add_o   = op_i != OP_SUB;
   assign is_imm_o   = op_i == OP_LDI;
   assign is_jump_o  = op_i == OP_JMP || op_i == OP_BZ;
   assign two_byte_o = op_i == OP_LDI || is_jump_o;
   assign is_mem_o   = op_i == OP_LD || op_i == OP_ST;
endmodule

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle fetch/decode/execute sequencer with registered datapath controls
module cpu_seq_ctrl
   import cpu_seq_pkg::*;
#(
   parameter logic [7:0] RESET_PC    = 8'h00,
   parameter int         PC_STEP     = 1,
   parameter int         MEM_TIMEOUT = 15
)(
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] instr,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic       alu_zero,
   input  logic       mem_ready,
   output logic [7:0] pc,
   output logic [1:0] rf_dst,
   output logic [1:0] rf_src1,
   output logic [1:0] rf_src2,
   output logic       rf_we,
   output logic [2:0] alu_op,
   output logic       is_add,
   output logic       is_imm,
   output logic [7:0] imm,
   output logic       ram_cs,
   output logic       ram_we,
   output logic       ram_rd,
   output logic       halted,
   output logic       mem_err
);
   state_t     st_q, st_d;
   logic [7:0] ir_q, ir_d, pc_d, imm_d;
   logic [3:0] cnt_q, cnt_d;
   logic       z_q, z_d, err_d;
   logic [2:0] dec_alu_op;
   logic       dec_add, dec_imm, dec_two, dec_mem, dec_jump;
   logic [3:0] op_d;
   assign ir_d = (st_q == S_FETCH && instr_valid) ? instr : ir_q;
   assign op_d = ir_d[7:4];
   cpu_seq_decode u_dec (
      .op_i      (op_d),
      .alu_op_o  (dec_alu_op),
      .is_add_o  (dec_add),
      .is_imm_o  (dec_imm),
      .two_byte_o(dec_two),
      .is_mem_o  (dec_mem),
      .is_jump_o (dec_jump)
   );
   // next state, program counter, zero flag and memory wait counter
   always_comb begin
      st_d  = st_q;
      pc_d  = pc;
      imm_d = imm;
      z_d   = z_q;
      err_d = mem_err;
      cnt_d = '0;
      case (st_q)
         S_FETCH: if (instr_valid) begin
            pc_d = pc + 8'(PC_STEP);
            st_d = dec_two ? S_FETCH2 : dec_mem ? S_MEM : op_d == OP_HALT ? S_HALT :
                   op_d inside {[OP_MOV:OP_OR]} ? S_EXEC : S_FETCH;
         end
         S_FETCH2: if (instr_valid) begin
            imm_d = instr;
            pc_d  = (dec_jump && (op_d == OP_JMP || z_q)) ? instr : pc + 8'(PC_STEP);
            st_d  = dec_jump ? S_FETCH : S_EXEC;
         end
         S_EXEC: begin
            z_d  = op_d inside {[OP_ADD:OP_OR]} ? alu_zero : z_q;
            st_d = S_FETCH;
         end
         S_MEM: begin
            if (mem_ready) st_d = op_d == OP_LD ? S_WB : S_FETCH;
            else if (cnt_q == 4'(MEM_TIMEOUT - 1)) begin
               st_d  = S_HALT;
               err_d = 1'b1;
            end else cnt_d = cnt_q + 4'd1;
         end
         S_WB: st_d = S_FETCH;
         default: ;
      endcase
   end
   // state and outputs registered from the state being entered
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         st_q        <= S_FETCH;
         ir_q        <= '0;
         pc          <= RESET_PC;
         imm         <= '0;
         z_q         <= 1'b0;
         mem_err     <= 1'b0;
         cnt_q       <= '0;
         instr_ready <= 1'b1;
         rf_we       <= 1'b0;
         rf_dst      <= '0;
         rf_src1     <= '0;
         rf_src2     <= '0;
         alu_op      <= ALU_FWD;
         is_add      <= 1'b0;
         is_imm      <= 1'b0;
         ram_cs      <= 1'b0;
         ram_rd      <= 1'b0;
         ram_we      <= 1'b0;
         halted      <= 1'b0;
      end else begin
         st_q        <= st_d;
         ir_q        <= ir_d;
         pc          <= pc_d;
         imm         <= imm_d;
         z_q         <= z_d;
         mem_err     <= err_d;
         cnt_q       <= cnt_d;
         instr_ready <= st_d == S_FETCH || st_d == S_FETCH2;
         rf_we       <= st_d == S_EXEC || st_d == S_WB;
         rf_dst      <= (st_d == S_EXEC || st_d == S_WB) ? ir_d[3:2] : 2'd0;
         rf_src1     <= st_d == S_EXEC ? ir_d[3:2] :
                        st_d == S_MEM ? (op_d == OP_LD ? ir_d[1:0] : ir_d[3:2]) : 2'd0;
         rf_src2     <= (st_d == S_EXEC || st_d == S_MEM) ? ir_d[1:0] : 2'd0;
         alu_op      <= st_d == S_EXEC ? dec_alu_op : ALU_FWD;
         is_add      <= st_d == S_EXEC && dec_add;
         is_imm      <= st_d == S_EXEC && dec_imm;
         ram_cs      <= st_d == S_MEM;
         ram_rd      <= st_d == S_MEM && op_d == OP_LD;
         ram_we      <= st_d == S_MEM && op_d == OP_ST;
         halted      <= st_d == S_HALT;
      end
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: per-instruction behavioural model driving scenario and random tests
module tb_cpu_seq_ctrl;
   logic       CLK = 1'b0, RESET = 1'b1;
   logic [7:0] instr = '0;
   logic       instr_valid = 1'b0, alu_zero = 1'b0, mem_ready = 1'b0;
   logic       instr_ready, rf_we, is_add, is_imm, ram_cs, ram_we, ram_rd, halted, mem_err;
   logic [7:0] pc, imm;
   logic [1:0] rf_dst, rf_src1, rf_src2;
   logic [2:0] alu_op;
   int         tests = 0, fails = 0, cyc = 0;
   logic [7:0] m_pc;
   logic       m_z;
   logic [4:0] exec_tab [0:5] = '{5'b000_1_1, 5'b000_1_0, 5'b001_1_0, 5'b001_0_0, 5'b010_1_0, 5'b011_1_0};
   always #5 CLK = ~CLK;
   cpu_seq_ctrl #(.RESET_PC(8'h10), .PC_STEP(1), .MEM_TIMEOUT(15)) dut (
      .CLK(CLK), .RESET(RESET), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .alu_zero(alu_zero), .mem_ready(mem_ready), .pc(pc), .rf_dst(rf_dst), .rf_src1(rf_src1),
      .rf_src2(rf_src2), .rf_we(rf_we), .alu_op(alu_op), .is_add(is_add), .is_imm(is_imm), .imm(imm),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_rd(ram_rd), .halted(halted), .mem_err(mem_err));
   task automatic tick;
      @(posedge CLK);
      #1;
      cyc++;
   endtask
   task automatic do_reset;
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      m_pc = 8'h10;
      m_z  = 1'b0;
   endtask
   task automatic run_instr(input logic [7:0] b0, input logic [7:0] b1, input int gap, input int wait_n, input logic az);
      logic [3:0] op;
      logic [1:0] rd, rs;
      op = b0[7:4];
      rd = b0[3:2];
      rs = b0[1:0];
      tests++;
      if ({instr_ready, rf_we, ram_cs, halted, pc} !== {4'b1000, m_pc}) begin
         fails++;
         $display("FAIL fetch b0=%h got rdy/we/cs/halt=%b%b%b%b pc=%h want 1000 pc=%h", b0, instr_ready, rf_we, ram_cs, halted, pc, m_pc);
      end
      instr = b0;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      m_pc = m_pc + 8'd1;
      if (op == 4'h0 || op == 4'h8 || op == 4'h9) begin
         repeat (gap) begin
            tests++;
            if ({instr_ready, rf_we, pc} !== {2'b10, m_pc}) begin
               fails++;
               $display("FAIL fetch2_gap b0=%h got rdy=%b we=%b pc=%h want rdy=1 we=0 pc=%h", b0, instr_ready, rf_we, pc, m_pc);
            end
            tick();
         end
         tests++;
         if ({instr_ready, rf_we, pc} !== {2'b10, m_pc}) begin
            fails++;
            $display("FAIL fetch2 b0=%h got rdy=%b we=%b pc=%h want rdy=1 we=0 pc=%h", b0, instr_ready, rf_we, pc, m_pc);
         end
         instr = b1;
         instr_valid = 1'b1;
         tick();
         instr_valid = 1'b0;
         m_pc = (op == 4'h8 || (op == 4'h9 && m_z)) ? b1 : m_pc + 8'd1;
      end
      if (op <= 4'h5) begin
         alu_zero = az;
         tests++;
         if ({rf_we, rf_dst, rf_src1, rf_src2, alu_op, is_add, is_imm, instr_ready, ram_cs} !== {1'b1, rd, rd, rs, exec_tab[op], 2'b00}) begin
            fails++;
            $display("FAIL exec b0=%h got we=%b dst=%0d s1=%0d s2=%0d op=%b add=%b imm=%b rdy=%b cs=%b want dst=%0d s1=%0d s2=%0d ctl=%b",
                     b0, rf_we, rf_dst, rf_src1, rf_src2, alu_op, is_add, is_imm, instr_ready, ram_cs, rd, rd, rs, exec_tab[op]);
         end
         if (op == 4'h0) begin
            tests++;
            if (imm !== b1) begin
               fails++;
               $display("FAIL ldi_imm got %h want %h", imm, b1);
            end
         end
         if (op >= 4'h2) m_z = az;
         tick();
         alu_zero = 1'b0;
      end else if (op == 4'h6 || op == 4'h7) begin
         for (int i = 1; i <= 15; i++) begin
            tests++;
            if ({ram_cs, ram_rd, ram_we, rf_src1, rf_src2, instr_ready, rf_we} !== {1'b1, op == 4'h6, op == 4'h7, (op == 4'h6) ? rs : rd, rs, 2'b00}) begin
               fails++;
               $display("FAIL mem b0=%h cyc%0d got cs=%b rd=%b we=%b s1=%0d s2=%0d rdy=%b rfwe=%b", b0, i, ram_cs, ram_rd, ram_we, rf_src1, rf_src2, instr_ready, rf_we);
            end
            mem_ready = (i == wait_n);
            tick();
            mem_ready = 1'b0;
            if (i == wait_n) break;
         end
         if (wait_n > 15) begin
            tests++;
            if ({halted, mem_err, ram_cs, instr_ready} !== 4'b1100) begin
               fails++;
               $display("FAIL timeout got halt=%b err=%b cs=%b rdy=%b want 1100", halted, mem_err, ram_cs, instr_ready);
            end
            return;
         end
         if (op == 4'h6) begin
            tests++;
            if ({rf_we, rf_dst, alu_op, ram_cs} !== {1'b1, rd, 3'b000, 1'b0}) begin
               fails++;
               $display("FAIL wb got we=%b dst=%0d op=%b cs=%b want we=1 dst=%0d op=000 cs=0", rf_we, rf_dst, alu_op, ram_cs, rd);
            end
            tick();
         end
      end else if (op == 4'hF) begin
         tests++;
         if ({halted, instr_ready, rf_we, ram_cs} !== 4'b1000) begin
            fails++;
            $display("FAIL halt got halt=%b rdy=%b we=%b cs=%b want 1000", halted, instr_ready, rf_we, ram_cs);
         end
      end
   endtask
   task automatic test_reset;
      RESET = 1'b1;
      tick();
      tests++;
      if ({instr_ready, rf_we, ram_cs, ram_we, ram_rd, halted, mem_err, is_add, is_imm, alu_op, rf_dst, rf_src1, rf_src2, pc, imm}
          !== {9'b1_0000_0000, 3'b000, 6'b0, 8'h10, 8'h00}) begin
         fails++;
         $display("FAIL reset got rdy=%b we=%b cs=%b halt=%b err=%b pc=%h imm=%h want rdy=1 others 0 pc=10", instr_ready, rf_we, ram_cs, halted, mem_err, pc, imm);
      end
      do_reset();
   endtask
   task automatic test_stream;
      int c0;
      c0 = cyc;
      for (int k = 0; k < 4; k++) run_instr({4'h1, 4'(k * 5)}, 8'h00, 0, 0, 1'b0);
      tests++;
      if (cyc - c0 !== 8 || pc !== 8'h14) begin
         fails++;
         $display("FAIL stream_latency got %0d cycles pc=%h want 8 cycles pc=14", cyc - c0, pc);
      end
   endtask
   task automatic test_ldi;
      int c0;
      c0 = cyc;
      run_instr(8'h08, 8'hA5, 0, 0, 1'b0);
      tests++;
      if (cyc - c0 !== 3) begin
         fails++;
         $display("FAIL ldi_latency got %0d want 3", cyc - c0);
      end
   endtask
   task automatic test_sub_bz;
      run_instr(8'h37, 8'h00, 0, 0, 1'b1);
      run_instr(8'h90, 8'h40, 0, 0, 1'b0);
      tests++;
      if (pc !== 8'h40) begin
         fails++;
         $display("FAIL bz_taken got pc=%h want 40", pc);
      end
   endtask
   task automatic test_reset_mid_st;
      run_instr(8'h7D, 8'h00, 0, 99, 1'b0) ;
   endtask
   task automatic test_reset_in_mem;
      tests++;
      if (pc !== m_pc) begin
         fails++;
         $display("FAIL st_fetch got pc=%h want %h", pc, m_pc);
      end
      instr = 8'h7D;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      tests++;
      if ({ram_cs, ram_we, ram_rd} !== 3'b110) begin
         fails++;
         $display("FAIL st_mem got cs=%b we=%b rd=%b want 110", ram_cs, ram_we, ram_rd);
      end
      #2 RESET = 1'b1;
      #1;
      tests++;
      if ({ram_cs, ram_we, instr_ready, halted, mem_err, pc, imm} !== {5'b00100, 8'h10, 8'h00}) begin
         fails++;
         $display("FAIL st_async_reset got cs=%b we=%b rdy=%b halt=%b err=%b pc=%h imm=%h want 00100 pc=10 imm=00",
                  ram_cs, ram_we, instr_ready, halted, mem_err, pc, imm);
      end
      @(posedge CLK);
      #1;
      cyc++;
      RESET = 1'b0;
      m_pc = 8'h10;
      m_z  = 1'b0;
   endtask
   task automatic test_ld;
      int c0;
      c0 = cyc;
      run_instr(8'h61, 8'h00, 0, 3, 1'b0);
      tests++;
      if (cyc - c0 !== 5) begin
         fails++;
         $display("FAIL ld_latency got %0d want 5", cyc - c0);
      end
      c0 = cyc;
      run_instr(8'h7B, 8'h00, 0, 15, 1'b0);
      tests++;
      if (cyc - c0 !== 16 || mem_err !== 1'b0) begin
         fails++;
         $display("FAIL st_ready_at_limit got %0d cycles err=%b want 16 err=0", cyc - c0, mem_err);
      end
   endtask
   task automatic test_wrap;
      run_instr(8'h80, 8'hFF, 0, 0, 1'b0);
      run_instr(8'h80, 8'h00, 2, 0, 1'b0);
      tests++;
      if (pc !== 8'h00) begin
         fails++;
         $display("FAIL wrap_jmp got pc=%h want 00", pc);
      end
   endtask
   task automatic test_random;
      logic [3:0] op;
      for (int k = 0; k < 60; k++) begin
         op = 4'($urandom_range(0, 14));
         run_instr({op, 4'($urandom)}, 8'($urandom), $urandom_range(0, 2), $urandom_range(1, 6), 1'($urandom));
      end
   endtask
   task automatic test_timeout;
      run_instr(8'h61, 8'h00, 0, 99, 1'b0);
      instr = 8'h10;
      instr_valid = 1'b1;
      repeat (3) tick();
      instr_valid = 1'b0;
      tests++;
      if ({halted, mem_err, instr_ready, pc} !== {3'b110, m_pc}) begin
         fails++;
         $display("FAIL halt_sticky got halt=%b err=%b rdy=%b pc=%h want 110 pc=%h", halted, mem_err, instr_ready, pc, m_pc);
      end
      do_reset();
      run_instr(8'hF0, 8'h00, 0, 0, 1'b0);
      do_reset();
      tests++;
      if ({halted, mem_err, instr_ready, pc} !== {3'b001, 8'h10}) begin
         fails++;
         $display("FAIL reset_clears_halt got halt=%b err=%b rdy=%b pc=%h want 001 pc=10", halted, mem_err, instr_ready, pc);
      end
   endtask
   initial begin
      m_pc = 8'h10;
      m_z  = 1'b0;
      test_reset();
      test_stream();
      test_ldi();
      test_sub_bz();
      test_reset_in_mem();
      test_ld();
      test_wrap();
      test_random();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
